// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync receiver: recovers line/frame position from hsync/vsync, checks timing, reports lock
module vga_sync_rx #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HPULSE      = 96,
    parameter int VPULSE      = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       err_h,
    output logic       err_v
);

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } state_t;

    localparam logic [9:0] H_LAST   = 10'(HPIXELS - 1);
    localparam logic [9:0] HP_LAST  = 10'(HPULSE - 1);
    localparam logic [9:0] V_LAST   = 10'(VLINES - 1);
    localparam logic [9:0] VP_LAST  = 10'(VPULSE - 1);
    localparam logic [9:0] HBP_L    = 10'(HBP);
    localparam logic [9:0] HFP_L    = 10'(HFP);
    localparam logic [9:0] VBP_L    = 10'(VBP);
    localparam logic [9:0] VFP_L    = 10'(VFP);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [7:0] LOCK_CNT = 8'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic       hs_q, vs_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       h_seen_q, h_seen_d;
    logic       v_seen_q, v_seen_d;
    logic [7:0] good_q, good_d;
    logic       err_seen_q, err_seen_d;
    logic       err_h_q, err_h_d;
    logic       err_v_q, err_v_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    logic h_fall, h_rise, v_fall, v_rise;
    logic err_now, err_pulse;
    logic in_h, in_v;

    assign h_fall = hs_q & ~hsync;
    assign h_rise = ~hs_q & hsync;
    assign v_fall = vs_q & ~vsync;
    assign v_rise = ~vs_q & vsync;

    always_comb begin
        hcnt_d   = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
        vcnt_d   = vcnt_q;
        h_seen_d = h_seen_q | h_fall;
        v_seen_d = v_seen_q | v_fall;
        if (h_fall) begin
            hcnt_d = '0;
            if (vcnt_q != CNT_MAX) begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end
        if (v_fall) begin
            vcnt_d = '0;
        end
    end

    // Saturation is flagged on the step into 1023, so it fires once per runaway line.
    always_comb begin
        err_h_d = h_seen_q & ((h_fall & (hcnt_q != H_LAST)) |
                              (h_rise & (hcnt_q != HP_LAST)) |
                              (~h_fall & (hcnt_q == CNT_MAX - 10'd1)));
        err_v_d = v_seen_q & ((v_fall & (vcnt_q != V_LAST)) |
                              (v_rise & (vcnt_q != VP_LAST)));
    end

    assign err_now   = err_h_d | err_v_d;
    assign err_pulse = err_h_q | err_v_q;

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        err_seen_d = v_fall ? 1'b0 : (err_seen_q | err_now);
        fs_d       = 1'b0;
        fc_d       = fc_q;
        case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (v_fall) begin
                    if (err_seen_q | err_now) begin
                        good_d = '0;
                    end else if (good_q + 8'd1 >= LOCK_CNT) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end else if (err_now) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                // Drop on the registered pulse so locked falls the cycle after err_*.
                if (err_pulse) begin
                    state_d = TRACK;
                    good_d  = '0;
                end else if (v_fall) begin
                    fs_d = 1'b1;
                    fc_d = fc_q + 8'd1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            state_q    <= SEARCH;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            h_seen_q   <= 1'b0;
            v_seen_q   <= 1'b0;
            good_q     <= '0;
            err_seen_q <= 1'b0;
            err_h_q    <= 1'b0;
            err_v_q    <= 1'b0;
            fs_q       <= 1'b0;
            fc_q       <= '0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hsync;
            vs_q       <= vsync;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            h_seen_q   <= h_seen_d;
            v_seen_q   <= v_seen_d;
            good_q     <= good_d;
            err_seen_q <= err_seen_d;
            err_h_q    <= err_h_d;
            err_v_q    <= err_v_d;
            fs_q       <= fs_d;
            fc_q       <= fc_d;
        end
    end

    assign in_h = (hcnt_q >= HBP_L) && (hcnt_q < HFP_L);
    assign in_v = (vcnt_q >= VBP_L) && (vcnt_q < VFP_L);

    assign x           = in_h ? hcnt_q - HBP_L : '0;
    assign y           = in_v ? vcnt_q - VBP_L : '0;
    assign locked      = (state_q == LOCKED);
    assign active      = locked & in_h & in_v;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
    assign err_h       = err_h_q;
    assign err_v       = err_v_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - self-checking bench for vga_sync_rx on a reduced timing raster
module tb_vga_sync_rx;

    localparam int HPX = 20;
    localparam int VL  = 8;
    localparam int HP  = 3;
    localparam int VP  = 2;
    localparam int HBP = 5;
    localparam int HFP = 17;
    localparam int VBP = 2;
    localparam int VFP = 7;
    localparam int NDEC = 9;

    logic       dclk = 1'b0;
    logic       clr = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] x, y;
    logic       active, locked, frame_start, err_h, err_v;
    logic [7:0] frame_count;

    vga_sync_rx #(
        .HPIXELS(HPX), .VLINES(VL), .HPULSE(HP), .VPULSE(VP),
        .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP), .LOCK_FRAMES(2)
    ) dut (
        .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .active(active), .locked(locked),
        .frame_start(frame_start), .frame_count(frame_count),
        .err_h(err_h), .err_v(err_v)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        int v;
        int h;
        int ex;
        int ey;
        int eact;
    } dec_t;

    dec_t dec [NDEC];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fc_exp = 0;
    int exp_eh[$];
    int exp_ev[$];
    int exp_fs[$];
    int exp_fc[$];
    logic prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge dclk) cyc <= cyc + 1;

    // Scoreboard: every pulse the DUT emits must match the next expected cycle.
    always @(negedge dclk) begin
        if (prev_err) chk("locked_after_err", locked, 0);
        prev_err <= err_h | err_v;
        if (err_h) begin
            if (exp_eh.size() == 0) chk("err_h_unexpected", err_h, 0);
            else chk("err_h_cycle", cyc, exp_eh.pop_front());
        end
        if (err_v) begin
            if (exp_ev.size() == 0) chk("err_v_unexpected", err_v, 0);
            else chk("err_v_cycle", cyc, exp_ev.pop_front());
        end
        if (frame_start) begin
            if (exp_fs.size() == 0) chk("fs_unexpected", frame_start, 0);
            else begin
                chk("fs_cycle", cyc, exp_fs.pop_front());
                chk("fs_frame_count", frame_count, exp_fc.pop_front());
            end
        end
    end

    task automatic run_line(input int line, input int len, input bit vlow, input bit fall_err,
                            input bit rise_verr, input bit fs, input bit dchk);
        for (int i = 0; i < len; i++) begin
            @(negedge dclk);
            hsync = (i < HP) ? 1'b0 : 1'b1;
            vsync = vlow ? 1'b0 : 1'b1;
            if (i == 0) begin
                if (fall_err) exp_eh.push_back(cyc + 1);
                if (rise_verr) exp_ev.push_back(cyc + 1);
                if (fs) begin
                    exp_fs.push_back(cyc + 1);
                    fc_exp = (fc_exp + 1) % 256;
                    exp_fc.push_back(fc_exp);
                end
            end
            if (i == 1023) exp_eh.push_back(cyc + 1);
            if (dchk) begin
                @(posedge dclk);
                #1;
                for (int k = 0; k < NDEC; k++) begin
                    if (dec[k].v == line && dec[k].h == i) begin
                        chk($sformatf("x_v%0d_h%0d", line, i), x, dec[k].ex);
                        chk($sformatf("y_v%0d_h%0d", line, i), y, dec[k].ey);
                        chk($sformatf("active_v%0d_h%0d", line, i), active, dec[k].eact);
                    end
                end
            end
        end
    endtask

    task automatic run_frame(input int vlow, input int bad_line, input int bad_len,
                             input bit fs, input bit dchk);
        for (int v = 0; v < VL; v++) begin
            run_line(v, (v == bad_line) ? bad_len : HPX, v < vlow,
                     (bad_line >= 0) && (v == bad_line + 1) && (bad_len != HPX),
                     (v == vlow) && (vlow != VP), fs && (v == 0), dchk);
        end
    endtask

    task automatic check_lock(input string name, input logic exp);
        @(posedge dclk);
        #1;
        chk(name, locked, exp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        chk({tag, "_err_h"}, err_h, 0);
        chk({tag, "_err_v"}, err_v, 0);
    endtask

    initial begin
        dec[0] = '{2, 5, 0, 0, 1};
        dec[1] = '{2, 16, 11, 0, 1};
        dec[2] = '{2, 17, 0, 0, 0};
        dec[3] = '{2, 4, 0, 0, 0};
        dec[4] = '{6, 5, 0, 4, 1};
        dec[5] = '{7, 5, 0, 0, 0};
        dec[6] = '{1, 10, 5, 0, 0};
        dec[7] = '{4, 10, 5, 2, 1};
        dec[8] = '{0, 0, 0, 0, 0};

        clr = 1'b0;
        repeat (3) @(negedge dclk);
        check_zero("reset");
        clr = 1'b1;

        // Clean frames: lock after the third vsync fall, first frame_start on the fourth.
        run_frame(VP, -1, HPX, 0, 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("locked_before_3rd_fall", 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("locked_after_3rd_fall", 1);
        run_frame(VP, -1, HPX, 1, 1);

        // One short line while locked, then two clean frames to relock.
        run_frame(VP, 3, HPX - 1, 1, 0);
        check_lock("unlocked_after_short_line", 0);
        run_frame(VP, -1, HPX, 0, 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("not_yet_relocked", 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("relocked_after_short", 1);

        // Runaway line (hsync high 1100 clocks), then an over-long vsync pulse while tracking.
        run_frame(VP, 2, HP + 1100, 1, 0);
        check_lock("unlocked_after_runaway", 0);
        run_frame(3, -1, HPX, 0, 0);
        run_frame(VP, -1, HPX, 0, 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("not_relocked_after_vlong", 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("relocked_after_vlong", 1);

        for (int f = 0; f < 256; f++) run_frame(VP, -1, HPX, 1, 0);
        check_lock("locked_after_wrap_frames", 1);
        chk("frame_count_wrapped", frame_count, fc_exp);

        // Asynchronous reset in the middle of a line.
        run_line(0, 7, 1, 0, 0, 1, 0);
        @(negedge dclk);
        #2;
        clr = 1'b0;
        #1;
        check_zero("midline_reset");
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (2) @(negedge dclk);
        clr = 1'b1;
        run_frame(VP, -1, HPX, 0, 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("post_reset_not_locked", 0);
        run_frame(VP, -1, HPX, 0, 0);
        check_lock("post_reset_relocked", 1);

        repeat (3) @(negedge dclk);
        chk("err_h_pending", exp_eh.size(), 0);
        chk("err_v_pending", exp_ev.size(), 0);
        chk("fs_pending", exp_fs.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
Sink-side VGA timing receiver: samples hsync/vsync on the pixel clock, recovers line/frame position, validates 640x480 timing and reports lock. Sits opposite the VGA sync generator. Used for in-system loopback of the generator's sync outputs and as the timing reference for pixel-capture logic. Pure dclk domain; no CDC.

Parameters:
HPIXELS, 800, pixel clocks per line (fall-to-fall of hsync)
VLINES, 521, lines per frame (hsync falls between vsync falls)
HPULSE, 96, hsync low width in clocks
VPULSE, 2, vsync low width in lines
HBP, 144, first visible hcnt
HFP, 784, first non-visible hcnt after visible region
VBP, 31, first visible vcnt
VFP, 511, first non-visible vcnt after visible region
LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
dclk  input  1  pixel clock (25 MHz)
clr  input  1  asynchronous, active-low reset
hsync  input  1  horizontal sync, active-low, dclk-synchronous
vsync  input  1  vertical sync, active-low, dclk-synchronous
x  output  10  visible column 0..639, else 0
y  output  10  visible row 0..479, else 0
active  output  1  locked and inside visible window
locked  output  1  timing lock
frame_start  output  1  one-cycle pulse at vsync fall while locked
frame_count  output  8  frames since reset, wraps
err_h  output  1  one-cycle pulse, horizontal timing error
err_v  output  1  one-cycle pulse, vertical timing error

Behaviour:
- Reset (clr low, async): all outputs 0; hcnt=vcnt=0; hs_q=vs_q=1; FSM=SEARCH; good count 0; seen-flags cleared.
- Edges: hs_q/vs_q registered copies; fall = q&~in, rise = ~q&in, evaluated at each dclk edge.
- hcnt (10b): hsync fall -> 0; else +1, saturating at 1023.
- vcnt (10b): vsync fall -> 0 (wins over simultaneous hsync fall); else hsync fall -> +1, saturating at 1023.
- H checks (only after first hsync fall since reset): fall with pre-update hcnt != HPIXELS-1 -> err_h; rise with hcnt != HPULSE-1 -> err_h; hcnt reaching 1023 -> err_h once (no repeat until next fall).
- V checks (only after first vsync fall): vsync fall with pre-update vcnt != VLINES-1 -> err_v; vsync rise with pre-update vcnt != VPULSE-1 -> err_v.
- err_h/err_v registered; assert the cycle after the offending edge, width 1.
- FSM: SEARCH -> TRACK on first vsync fall (no credit). TRACK: each vsync fall with no error since previous vsync fall increments good count; any error clears count; count==LOCK_FRAMES -> LOCKED. LOCKED: any error -> TRACK, count 0, locked low the cycle after the error pulse.
- locked=1 only in LOCKED. frame_start pulses on vsync fall in LOCKED (incl. the fall that enters LOCKED: no); frame_count increments with each frame_start, 255 wraps to 0.
- x = hcnt-HBP when HBP<=hcnt<HFP else 0; y = vcnt-VBP when VBP<=vcnt<VFP else 0; active = locked & both windows. Combinational decode of registered counters (changes only on dclk edge).
- Reset mid-frame: immediate return to reset state; relock requires full SEARCH/TRACK sequence.

Test Plan:
- Clean generator timing, 4 frames -> err_h/err_v never assert; locked rises after 3rd vsync fall; frame_start at 4th vsync fall; frame_count=1.
- Locked, sample hcnt=144/vcnt=31 -> x=0,y=0,active=1; hcnt=783 -> x=639; hcnt=784 -> active=0,x=0; vcnt=510 -> y=479.
- Locked, one line shortened to 799 clocks -> err_h one cycle, locked drops next cycle; 2 clean frames later relocks.
- Locked, hsync held high 1100 clocks -> single err_h when hcnt hits 1023; locked=0; next fall gives another err_h (length mismatch).
- vsync low 3 lines -> err_v at vsync rise; TRACK count cleared.
- frame_count forced through 256 locked frames -> wraps 255->0; clr pulsed low mid-line -> all outputs 0 immediately, SEARCH.
